// File: rtl/exec_pkg.sv
// Shared types for the exec_unit execute stage: opcodes, FSM states and field widths.
package exec_pkg;

  localparam int unsigned OPC_WIDTH = 4;

  typedef enum logic [OPC_WIDTH-1:0] {
    OpNop = 4'h0,
    OpMov = 4'h1,
    OpSub = 4'h2,
    OpAnd = 4'h3,
    OpOr  = 4'h4,
    OpXor = 4'h5,
    OpShl = 4'h6,
    OpShr = 4'h7,
    OpAdc = 4'h8,
    OpSbc = 4'h9,
    OpOut = 4'hB,
    OpAdd = 4'hD,
    OpLdi = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StOutWait
  } state_e;

endpackage

// File: rtl/exec_regfile.sv
// Register file: two combinational read ports, one synchronous write port, synchronous clear.
module exec_regfile
  import exec_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_raddr_a,
  output logic [WORD_WIDTH-1:0] o_rdata_a,
  input  logic [ADDR_WIDTH-1:0] i_raddr_b,
  output logic [WORD_WIDTH-1:0] o_rdata_b,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WORD_WIDTH-1:0] i_wdata
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem_q [NumRegs];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q <= '{default: '0};
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = mem_q[i_raddr_a];
  assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/exec_unit.sv
// Execute stage: accepts one instruction per handshake, runs the ALU on the register file.
// Optional carry flag with ADC/SBC when EXEC_UNIT_CARRY_EN is defined.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 6,
  parameter int unsigned INST_WIDTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic                  i_inst_valid,
  output logic                  o_inst_ready,
  output logic                  o_busy,
  output logic [WORD_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_illegal,
  output logic                  o_zero
`ifdef EXEC_UNIT_CARRY_EN
  ,
  output logic                  o_carry
`endif
);

  if (INST_WIDTH != OPC_WIDTH + 2 * REG_ADDR_WIDTH) begin : g_bad_inst_width
    $error("INST_WIDTH must equal 4 + 2*REG_ADDR_WIDTH");
  end

  state_e                    state_q, state_d;
  logic [INST_WIDTH-1:0]     inst_q;
  logic [WORD_WIDTH-1:0]     out_data_q;
  logic                      zero_q;

  logic [OPC_WIDTH-1:0]      opc;
  logic [REG_ADDR_WIDTH-1:0] rd_addr, rs_addr;
  logic [WORD_WIDTH-1:0]     rd_val, rs_val, imm;
  logic [WORD_WIDTH-1:0]     result;
  logic                      wr_en, upd_zero, illegal, is_out, in_exec;

  assign opc     = inst_q[INST_WIDTH-1 -: OPC_WIDTH];
  assign rd_addr = inst_q[2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign rs_addr = inst_q[REG_ADDR_WIDTH-1:0];
  assign imm     = WORD_WIDTH'(rs_addr);
  assign in_exec = (state_q == StExec);

`ifdef EXEC_UNIT_CARRY_EN
  logic                carry_q, carry_d, upd_carry;
  logic [WORD_WIDTH:0] wide;
`endif

  exec_regfile #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_raddr_a (rd_addr),
    .o_rdata_a (rd_val),
    .i_raddr_b (rs_addr),
    .o_rdata_b (rs_val),
    .i_we      (in_exec && wr_en),
    .i_waddr   (rd_addr),
    .i_wdata   (result)
  );

  // ALU and decode; shifts by >= WORD_WIDTH naturally give 0 for logical shifts.
  always_comb begin
    result   = '0;
    wr_en    = 1'b0;
    upd_zero = 1'b0;
    illegal  = 1'b0;
    is_out   = 1'b0;
`ifdef EXEC_UNIT_CARRY_EN
    wide      = '0;
    carry_d   = carry_q;
    upd_carry = 1'b0;
`endif
    unique case (opcode_e'(opc))
      OpNop: ;
      OpMov: begin result = rs_val;           wr_en = 1'b1; upd_zero = 1'b1; end
      OpAnd: begin result = rd_val & rs_val;  wr_en = 1'b1; upd_zero = 1'b1; end
      OpOr:  begin result = rd_val | rs_val;  wr_en = 1'b1; upd_zero = 1'b1; end
      OpXor: begin result = rd_val ^ rs_val;  wr_en = 1'b1; upd_zero = 1'b1; end
      OpShl: begin result = rd_val << rs_addr; wr_en = 1'b1; upd_zero = 1'b1; end
      OpShr: begin result = rd_val >> rs_addr; wr_en = 1'b1; upd_zero = 1'b1; end
      OpLdi: begin result = imm;              wr_en = 1'b1; upd_zero = 1'b1; end
      OpOut: is_out = 1'b1;
`ifdef EXEC_UNIT_CARRY_EN
      OpAdd: begin
        wide = {1'b0, rd_val} + {1'b0, rs_val};
        result = wide[WORD_WIDTH-1:0]; carry_d = wide[WORD_WIDTH];
        wr_en = 1'b1; upd_zero = 1'b1; upd_carry = 1'b1;
      end
      OpSub: begin
        // Carry after subtraction means "no borrow".
        wide = {1'b0, rd_val} - {1'b0, rs_val};
        result = wide[WORD_WIDTH-1:0]; carry_d = ~wide[WORD_WIDTH];
        wr_en = 1'b1; upd_zero = 1'b1; upd_carry = 1'b1;
      end
      OpAdc: begin
        wide = {1'b0, rd_val} + {1'b0, rs_val} + (WORD_WIDTH + 1)'(carry_q);
        result = wide[WORD_WIDTH-1:0]; carry_d = wide[WORD_WIDTH];
        wr_en = 1'b1; upd_zero = 1'b1; upd_carry = 1'b1;
      end
      OpSbc: begin
        wide = {1'b0, rd_val} - {1'b0, rs_val} - (WORD_WIDTH + 1)'(~carry_q);
        result = wide[WORD_WIDTH-1:0]; carry_d = ~wide[WORD_WIDTH];
        wr_en = 1'b1; upd_zero = 1'b1; upd_carry = 1'b1;
      end
`else
      OpAdd: begin result = rd_val + rs_val;  wr_en = 1'b1; upd_zero = 1'b1; end
      OpSub: begin result = rd_val - rs_val;  wr_en = 1'b1; upd_zero = 1'b1; end
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      out_data_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && i_inst_valid) inst_q <= i_inst;
      if (in_exec && is_out)   out_data_q <= rd_val;
      if (in_exec && upd_zero) zero_q     <= (result == '0);
    end
  end

`ifdef EXEC_UNIT_CARRY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      carry_q <= 1'b0;
    end else if (in_exec && upd_carry) begin
      carry_q <= carry_d;
    end
  end
  assign o_carry = carry_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (i_inst_valid) state_d = StExec;
      StExec:    state_d = is_out ? StOutWait : StIdle;
      StOutWait: if (i_out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    o_inst_ready = (state_q == StIdle);
    o_busy       = (state_q != StIdle);
    o_out_valid  = (state_q == StOutWait);
    o_illegal    = in_exec && illegal;
    o_out_data   = out_data_q;
    o_zero       = zero_q;
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; covers the carry path when EXEC_UNIT_CARRY_EN is set.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic        zero;
`ifdef EXEC_UNIT_CARRY_EN
  logic        carry;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inst       (inst),
    .i_inst_valid (inst_valid),
    .o_inst_ready (inst_ready),
    .o_busy       (busy),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_illegal    (illegal),
    .o_zero       (zero)
`ifdef EXEC_UNIT_CARRY_EN
    ,
    .o_carry      (carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input int rd, input int rs);
    return {op, 6'(rd), 6'(rs)};
  endfunction

  // Called at a negedge; returns at the negedge inside the EXEC cycle.
  task automatic send(input logic [15:0] word);
    int n = 0;
    while (!inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) check("ready_timeout", {31'b0, inst_ready}, 32'd1);
    inst = word;
    inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic exec(input logic [15:0] word);
    send(word);
    @(negedge clk);
  endtask

  task automatic read_reg(input int r, input logic [31:0] exp, input string tag);
    send(ins(4'hB, r, 0));
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst = '0;
    inst_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", {31'b0, inst_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);

    // LDI r1,5; LDI r2,7; ADD r1,r2; OUT r1 with back-pressure.
    exec(ins(4'hF, 1, 5));
    exec(ins(4'hF, 2, 7));
    exec(ins(4'hD, 1, 2));
    check("add_zero", {31'b0, zero}, 32'd0);
    send(ins(4'hB, 1, 0));
    check("exec_busy", {31'b0, busy}, 32'd1);
    check("exec_ready", {31'b0, inst_ready}, 32'd0);
    check("exec_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_data", out_data, 32'd12);
      check("hold_ready", {31'b0, inst_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_ready", {31'b0, inst_ready}, 32'd1);
    check("release_valid", {31'b0, out_valid}, 32'd0);

    // Zero flag and rd == rs.
    exec(ins(4'hF, 3, 1));
    check("ldi_zero", {31'b0, zero}, 32'd0);
    exec(ins(4'h2, 3, 3));
    check("sub_self_zero", {31'b0, zero}, 32'd1);
    exec(ins(4'hD, 3, 3));
    check("add_keep_zero", {31'b0, zero}, 32'd1);
    read_reg(3, 32'd0, "r3");
    exec(ins(4'h0, 0, 0));
    check("nop_zero", {31'b0, zero}, 32'd1);

    // Shifts, including amount >= word width.
    exec(ins(4'hF, 4, 63));
    check("ldi63_zero", {31'b0, zero}, 32'd0);
    exec(ins(4'h6, 4, 32));
    check("shl32_zero", {31'b0, zero}, 32'd1);
    read_reg(4, 32'd0, "r4");
    exec(ins(4'hF, 6, 63));
    exec(ins(4'h7, 6, 3));
    read_reg(6, 32'd7, "shr");
    exec(ins(4'hF, 5, 5));
    exec(ins(4'h6, 5, 30));
    read_reg(5, 32'h4000_0000, "shl30");

    // Logic ops and MOV.
    exec(ins(4'h1, 7, 6));
    exec(ins(4'h5, 7, 2));
    check("xor_zero", {31'b0, zero}, 32'd1);
    exec(ins(4'hF, 8, 12));
    exec(ins(4'h4, 8, 2));
    read_reg(8, 32'd15, "or");
    exec(ins(4'h3, 8, 1));
    read_reg(8, 32'd12, "and");

    // Wraparound: 0 - 1 then + 1.
    exec(ins(4'hF, 9, 1));
    exec(ins(4'h2, 10, 9));
    read_reg(10, 32'hFFFF_FFFF, "sub_wrap");
    exec(ins(4'hD, 10, 9));
    check("add_wrap_zero", {31'b0, zero}, 32'd1);
    read_reg(10, 32'd0, "add_wrap");

    // Illegal opcode E: one pulse, no write, zero unchanged.
    exec(ins(4'hF, 11, 1));
    send(ins(4'hE, 1, 2));
    check("illegal_pulse", {31'b0, illegal}, 32'd1);
    @(negedge clk);
    check("illegal_clear", {31'b0, illegal}, 32'd0);
    check("illegal_zero", {31'b0, zero}, 32'd0);
    check("illegal_idle", {31'b0, inst_ready}, 32'd1);
    read_reg(1, 32'd12, "illegal_nowrite");
`ifndef EXEC_UNIT_CARRY_EN
    send(ins(4'h8, 1, 2));
    check("op8_illegal", {31'b0, illegal}, 32'd1);
    @(negedge clk);
    read_reg(1, 32'd12, "op8_nowrite");
`endif

    // Reset while OUT is pending.
    send(ins(4'hB, 1, 0));
    @(negedge clk);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drop_valid", {31'b0, out_valid}, 32'd0);
    check("rst_drop_ready", {31'b0, inst_ready}, 32'd1);
    check("rst_drop_zero", {31'b0, zero}, 32'd0);
    read_reg(1, 32'd0, "rst_r1");
    read_reg(2, 32'd0, "rst_r2");

`ifdef EXEC_UNIT_CARRY_EN
    check("carry_rst", {31'b0, carry}, 32'd0);
    exec(ins(4'hF, 1, 0));
    exec(ins(4'hF, 2, 1));
    exec(ins(4'h2, 1, 2));
    check("sub_borrow_carry", {31'b0, carry}, 32'd0);
    read_reg(1, 32'hFFFF_FFFF, "carry_sub");
    exec(ins(4'h8, 1, 2));
    check("adc_carry", {31'b0, carry}, 32'd1);
    read_reg(1, 32'd0, "adc");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end

endmodule
